// File: rtl/datapath_gen.sv
// datapath_gen: parametrised CPU datapath with A/B operand registers, ALU, ANS, flags, IR, PC and an iterative multiplier.
// Latency: ALU results, IR and PC land on the next Clk edge; MUL writes ANS W+1 edges after its start strobe.
// Backpressure: while Busy, Aload/Bload/ANSload are ignored; IR and PC keep operating.
//
// Ports:
//   Clk, Reset (sync, active-low)
//   InputA/InputB: external operands; InputA also loads the IR
//   A_select/B_select: operand source (0 = external input, 1 = ANS)
//   Aload/Bload/ANSload/IRload/PCload: register strobes; mode: ALU op; JSM: PC next-value select
//   select_mode: Output mux (00 ANS, 01 A, 10 B, 11 PC)
//   IRCU: opcode IR[W-1:W-4]; Output; PC; Zero/Carry flags; Busy/Done multiplier status
module datapath_gen #(
    parameter int W  = 8,
    parameter int PW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [W-1:0]  InputA,
    input  logic [W-1:0]  InputB,
    input  logic          A_select,
    input  logic          B_select,
    input  logic          Aload,
    input  logic          Bload,
    input  logic [3:0]    mode,
    input  logic          IRload,
    input  logic          PCload,
    input  logic          ANSload,
    input  logic [1:0]    JSM,
    input  logic [1:0]    select_mode,
    output logic [3:0]    IRCU,
    output logic [W-1:0]  Output,
    output logic [PW-1:0] PC,
    output logic          Zero,
    output logic          Carry,
    output logic          Busy,
    output logic          Done
);

    localparam int CW = $clog2(W);
    localparam int OW = W - 4;

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]    a_q, b_q, ans_q, ir_q;
    logic [PW-1:0]   pc_q;
    logic            zero_q, carry_q, done_q;

    // Multiplier working set: shifted multiplicand, remaining multiplier bits, partial sum.
    logic [2*W-1:0]  mcand_q, acc_q, acc_nxt;
    logic [W-1:0]    mplier_q;
    logic [CW-1:0]   cnt_q;
    logic            mul_last;

    logic [W-1:0]    alu_res;
    logic            alu_c;
    logic [W:0]      sum, dif, inc, dec;

    logic            busy;
    logic            ans_op, mul_start;
    logic [PW-1:0]   operand, pc_inc, pc_nxt;
    logic [W-1:0]    pc_ext;

    assign busy      = (state == ST_MUL);
    assign ans_op    = ANSload && !busy && (mode != 4'd12);
    assign mul_start = ANSload && !busy && (mode == 4'd12);
    assign mul_last  = busy && (cnt_q == CW'(W - 1));
    assign acc_nxt   = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Operand field IR[W-5:0] sized to the PC; PC sized to the data width.
    generate
        if (OW >= PW) begin : g_op_trunc
            assign operand = ir_q[PW-1:0];
        end else begin : g_op_ext
            assign operand = {{(PW - OW){1'b0}}, ir_q[OW-1:0]};
        end
        if (W > PW) begin : g_pc_ext
            assign pc_ext = {{(W - PW){1'b0}}, pc_q};
        end else begin : g_pc_trunc
            assign pc_ext = pc_q[W-1:0];
        end
    endgenerate

    // ALU: width-extended arithmetic so the top bit is carry-out or borrow.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        sum     = {1'b0, a_q} + {1'b0, b_q};
        dif     = {1'b0, a_q} - {1'b0, b_q};
        inc     = {1'b0, a_q} + (W + 1)'(1);
        dec     = {1'b0, a_q} - (W + 1)'(1);
        case (mode)
            4'd0:  alu_res = a_q;
            4'd1:  alu_res = b_q;
            4'd2:  {alu_c, alu_res} = sum;
            4'd3:  {alu_c, alu_res} = dif;
            4'd4:  alu_res = a_q & b_q;
            4'd5:  alu_res = a_q | b_q;
            4'd6:  alu_res = a_q ^ b_q;
            4'd7:  alu_res = ~a_q;
            4'd8:  begin alu_res = {a_q[W-2:0], 1'b0}; alu_c = a_q[W-1]; end
            4'd9:  begin alu_res = {1'b0, a_q[W-1:1]}; alu_c = a_q[0];   end
            4'd10: {alu_c, alu_res} = inc;
            4'd11: {alu_c, alu_res} = dec;
            4'd13: {alu_c, alu_res} = dif;
            default: ;
        endcase
    end

    // PC next value; conditional jumps look at the flags before this edge.
    always_comb begin
        pc_inc = pc_q + PW'(1);
        pc_nxt = pc_q;
        if (PCload) begin
            case (JSM)
                2'b00:   pc_nxt = pc_inc;
                2'b01:   pc_nxt = operand;
                2'b10:   pc_nxt = zero_q  ? operand : pc_inc;
                default: pc_nxt = carry_q ? operand : pc_inc;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (mul_start) state_nxt = ST_MUL;
            ST_MUL:  if (mul_last)  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            ans_q    <= '0;
            ir_q     <= '0;
            pc_q     <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state  <= state_nxt;
            done_q <= mul_last;
            pc_q   <= pc_nxt;
            if (IRload) ir_q <= InputA;

            if (!busy) begin
                if (Aload) a_q <= A_select ? ans_q : InputA;
                if (Bload) b_q <= B_select ? ans_q : InputB;
            end

            if (ans_op) begin
                if (mode != 4'd13) ans_q <= alu_res;
                zero_q  <= (alu_res == '0);
                carry_q <= alu_c;
            end

            if (mul_start) begin
                mcand_q  <= {{W{1'b0}}, a_q};
                mplier_q <= b_q;
                acc_q    <= '0;
                cnt_q    <= '0;
            end else if (busy) begin
                mcand_q  <= {mcand_q[2*W-2:0], 1'b0};
                mplier_q <= {1'b0, mplier_q[W-1:1]};
                acc_q    <= acc_nxt;
                cnt_q    <= cnt_q + CW'(1);
                if (mul_last) begin
                    ans_q   <= acc_nxt[W-1:0];
                    carry_q <= |acc_nxt[2*W-1:W];
                    zero_q  <= (acc_nxt[W-1:0] == '0);
                end
            end
        end
    end

    always_comb begin
        case (select_mode)
            2'b00:   Output = ans_q;
            2'b01:   Output = a_q;
            2'b10:   Output = b_q;
            default: Output = pc_ext;
        endcase
    end

    assign IRCU  = ir_q[W-1:W-4];
    assign PC    = pc_q;
    assign Zero  = zero_q;
    assign Carry = carry_q;
    assign Busy  = busy;
    assign Done  = done_q;

endmodule

// File: tb/tb_datapath_gen.sv
// tb_datapath_gen: directed checks of datapath_gen (W=8, PW=8): reset, ALU table, MUL, IR/PC jumps, pre-edge reads.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled at the same point.
// Backpressure: every wait on the multiplier is bounded by a cycle budget.
module tb_datapath_gen;

    localparam int W  = 8;
    localparam int PW = 8;

    logic          Clk;
    logic          Reset;
    logic [W-1:0]  InputA, InputB;
    logic          A_select, B_select, Aload, Bload;
    logic [3:0]    mode;
    logic          IRload, PCload, ANSload;
    logic [1:0]    JSM, select_mode;
    logic [3:0]    IRCU;
    logic [W-1:0]  Output;
    logic [PW-1:0] PC;
    logic          Zero, Carry, Busy, Done;

    datapath_gen #(.W(W), .PW(PW)) dut (
        .Clk(Clk), .Reset(Reset), .InputA(InputA), .InputB(InputB),
        .A_select(A_select), .B_select(B_select), .Aload(Aload), .Bload(Bload),
        .mode(mode), .IRload(IRload), .PCload(PCload), .ANSload(ANSload),
        .JSM(JSM), .select_mode(select_mode), .IRCU(IRCU), .Output(Output),
        .PC(PC), .Zero(Zero), .Carry(Carry), .Busy(Busy), .Done(Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] m;
        logic [7:0] ans;
        logic       z;
        logic       c;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic show(input logic [1:0] sel);
        select_mode = sel;
        #1;
    endtask

    task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
        InputA = a; InputB = b; A_select = 1'b0; B_select = 1'b0;
        Aload = 1'b1; Bload = 1'b1;
        tick();
        Aload = 1'b0; Bload = 1'b0;
    endtask

    task automatic alu_op(input logic [3:0] m);
        mode = m; ANSload = 1'b1;
        tick();
        ANSload = 1'b0;
    endtask

    int busy_cnt, done_cnt, n;

    initial begin
        vecs[0]  = '{8'h02, 8'h06, 4'd2,  8'h08, 1'b0, 1'b0};
        vecs[1]  = '{8'h02, 8'h06, 4'd3,  8'hFC, 1'b0, 1'b1};
        vecs[2]  = '{8'hF0, 8'h20, 4'd2,  8'h10, 1'b0, 1'b1};
        vecs[3]  = '{8'hFF, 8'h01, 4'd2,  8'h00, 1'b1, 1'b1};
        vecs[4]  = '{8'hCC, 8'hAA, 4'd4,  8'h88, 1'b0, 1'b0};
        vecs[5]  = '{8'hCC, 8'hAA, 4'd5,  8'hEE, 1'b0, 1'b0};
        vecs[6]  = '{8'hCC, 8'hAA, 4'd6,  8'h66, 1'b0, 1'b0};
        vecs[7]  = '{8'h0F, 8'h00, 4'd7,  8'hF0, 1'b0, 1'b0};
        vecs[8]  = '{8'h81, 8'h00, 4'd8,  8'h02, 1'b0, 1'b1};
        vecs[9]  = '{8'h81, 8'h00, 4'd9,  8'h40, 1'b0, 1'b1};
        vecs[10] = '{8'hFF, 8'h00, 4'd10, 8'h00, 1'b1, 1'b1};
        vecs[11] = '{8'h00, 8'h00, 4'd11, 8'hFF, 1'b0, 1'b1};
        vecs[12] = '{8'h5A, 8'h33, 4'd1,  8'h33, 1'b0, 1'b0};
        vecs[13] = '{8'h5A, 8'h33, 4'd0,  8'h5A, 1'b0, 1'b0};
        vecs[14] = '{8'h06, 8'h06, 4'd13, 8'h5A, 1'b1, 1'b0};
        vecs[15] = '{8'h03, 8'h06, 4'd13, 8'h5A, 1'b0, 1'b1};
        vecs[16] = '{8'h5A, 8'h33, 4'd14, 8'h00, 1'b1, 1'b0};
        vecs[17] = '{8'h07, 8'h07, 4'd3,  8'h00, 1'b1, 1'b0};
        vecs[18] = '{8'h40, 8'h00, 4'd8,  8'h80, 1'b0, 1'b0};
        vecs[19] = '{8'h12, 8'h34, 4'd15, 8'h00, 1'b1, 1'b0};

        Reset = 1'b0; InputA = '0; InputB = '0; A_select = 1'b0; B_select = 1'b0;
        Aload = 1'b0; Bload = 1'b0; mode = 4'd0; IRload = 1'b0; PCload = 1'b0;
        ANSload = 1'b0; JSM = 2'b00; select_mode = 2'b00;
        tick();
        Reset = 1'b1;

        // Arbitrary activity, then a single reset edge.
        load_ab(8'h55, 8'h66);
        alu_op(4'd2);
        InputA = 8'h35; IRload = 1'b1; PCload = 1'b1; JSM = 2'b00;
        tick();
        IRload = 1'b0; PCload = 1'b0;
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        show(2'b00);
        check("rst_ans", int'(Output), 0);
        check("rst_pc", int'(PC), 0);
        check("rst_ircu", int'(IRCU), 0);
        check("rst_zero", int'(Zero), 0);
        check("rst_carry", int'(Carry), 0);
        check("rst_busy", int'(Busy), 0);
        check("rst_done", int'(Done), 0);
        show(2'b01);
        check("rst_a", int'(Output), 0);
        show(2'b10);
        check("rst_b", int'(Output), 0);
        show(2'b00);

        // ALU table.
        for (int i = 0; i < 20; i++) begin
            load_ab(vecs[i].a, vecs[i].b);
            alu_op(vecs[i].m);
            check($sformatf("alu%0d_ans", i), int'(Output), int'(vecs[i].ans));
            check($sformatf("alu%0d_zero", i), int'(Zero), int'(vecs[i].z));
            check($sformatf("alu%0d_carry", i), int'(Carry), int'(vecs[i].c));
        end

        // MUL 13*11 with Aload and ANSload attempts while busy.
        load_ab(8'd13, 8'd11);
        mode = 4'd12; ANSload = 1'b1;
        tick();
        ANSload = 1'b0;
        check("mul1_busy_start", int'(Busy), 1);
        busy_cnt = int'(Busy); done_cnt = int'(Done);
        InputA = 8'h77; A_select = 1'b0; Aload = 1'b1; mode = 4'd2; ANSload = 1'b1;
        tick();
        Aload = 1'b0; ANSload = 1'b0;
        busy_cnt += int'(Busy); done_cnt += int'(Done);
        repeat (18) begin
            tick();
            busy_cnt += int'(Busy); done_cnt += int'(Done);
        end
        check("mul1_busy_cycles", busy_cnt, 8);
        check("mul1_done_pulses", done_cnt, 1);
        show(2'b00);
        check("mul1_ans", int'(Output), 8'h8F);
        check("mul1_carry", int'(Carry), 0);
        check("mul1_zero", int'(Zero), 0);
        show(2'b01);
        check("mul1_a_held", int'(Output), 13);
        show(2'b00);

        // MUL 32*16: high half nonzero, low half zero.
        load_ab(8'd32, 8'd16);
        mode = 4'd12; ANSload = 1'b1;
        tick();
        ANSload = 1'b0;
        n = 0;
        while (!Done && n < 40) begin
            tick();
            n++;
        end
        check("mul2_done_seen", int'(Done), 1);
        check("mul2_edges", n, 8);
        check("mul2_ans", int'(Output), 0);
        check("mul2_carry", int'(Carry), 1);
        check("mul2_zero", int'(Zero), 1);

        // Old ANS feeds A while ANS takes the new result on the same edge.
        load_ab(8'h02, 8'h06);
        alu_op(4'd2);
        InputB = 8'h10; Bload = 1'b1;
        tick();
        Bload = 1'b0;
        A_select = 1'b1; Aload = 1'b1; mode = 4'd1; ANSload = 1'b1;
        tick();
        A_select = 1'b0; Aload = 1'b0; ANSload = 1'b0;
        show(2'b01);
        check("fwd_a_old_ans", int'(Output), 8'h08);
        show(2'b00);
        check("fwd_ans_new", int'(Output), 8'h10);

        // IR and PC: flags set to Zero=0, Carry=1 first.
        load_ab(8'h02, 8'h06);
        alu_op(4'd3);
        InputA = 8'h35; IRload = 1'b1;
        tick();
        IRload = 1'b0;
        check("ir_ircu", int'(IRCU), 3);
        PCload = 1'b1; JSM = 2'b01;
        tick();
        check("pc_jmp", int'(PC), 5);
        JSM = 2'b10;
        tick();
        check("pc_jz_not_taken", int'(PC), 6);
        JSM = 2'b11;
        tick();
        check("pc_jc_taken", int'(PC), 5);
        PCload = 1'b0;
        tick();
        check("pc_hold", int'(PC), 5);
        show(2'b11);
        check("out_pc", int'(Output), 5);
        show(2'b00);
        PCload = 1'b1; JSM = 2'b00;
        repeat (250) tick();
        check("pc_ff", int'(PC), 8'hFF);
        tick();
        check("pc_wrap", int'(PC), 0);
        PCload = 1'b0;

        // Reset in the middle of a multiply.
        load_ab(8'd13, 8'd11);
        mode = 4'd12; ANSload = 1'b1;
        tick();
        ANSload = 1'b0;
        repeat (3) tick();
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        check("abort_busy", int'(Busy), 0);
        check("abort_ans", int'(Output), 0);
        done_cnt = int'(Done);
        repeat (15) begin
            tick();
            done_cnt += int'(Done);
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_ans_late", int'(Output), 0);
        check("abort_carry", int'(Carry), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
